// File: rtl/adder_share_pkg.sv
// adder_share_pkg: state encoding and requester id width shared by the adder arbiter
package adder_share_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;
   localparam int ID_W = 1;
endpackage

// File: rtl/adder_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, favouring the requester not served last on a tie
module rr_arb2
   import adder_share_pkg::*;
(
   input  logic [1:0]      i_valid,
   input  logic [ID_W-1:0] i_last,
   output logic [1:0]      o_gnt,
   output logic [ID_W-1:0] o_id
);
   always_comb begin
      o_id  = (&i_valid) ? ~i_last : i_valid[1];
      o_gnt = (|i_valid) ? (o_id ? 2'b10 : 2'b01) : 2'b00;
   end
endmodule

// File: rtl/n_full_adder.sv
// n_full_adder: n-bit ripple-carry adder, carry-in 0, carry-out dropped
module n_full_adder #(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic [n-1:0] y1
);
   logic [n-1:0] w_c;
   always_comb begin
      w_c = '0;
      for (int k = 1; k < n; k++) w_c[k] = (a[k-1] & b[k-1]) | ((a[k-1] ^ b[k-1]) & w_c[k-1]);
   end
   assign y1 = a ^ b ^ w_c;
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one n_full_adder between two valid/ready requesters
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_id,
   output logic         busy
);
   state_t          r_state;
   logic [ID_W-1:0] r_last_grant;
   logic [ID_W-1:0] r_op_id;
   logic [N-1:0]    r_op_a;
   logic [N-1:0]    r_op_b;
   logic [N-1:0]    r_out_sum;
   logic [ID_W-1:0] r_out_id;
   logic [1:0]      w_gnt;
   logic [ID_W-1:0] w_gnt_id;
   logic [N-1:0]    w_y;
   logic            w_idle;
   rr_arb2 u_arb (
      .i_valid ({req1_valid, req0_valid}),
      .i_last  (r_last_grant),
      .o_gnt   (w_gnt),
      .o_id    (w_gnt_id)
   );
   // The adder only ever sees the latched operands, so port changes after accept are harmless.
   n_full_adder #(.n(N)) u_add (
      .a  (r_op_a),
      .b  (r_op_b),
      .y1 (w_y)
   );
   assign w_idle     = (r_state == S_IDLE);
   assign req0_ready = w_idle & w_gnt[0];
   assign req1_ready = w_idle & w_gnt[1];
   assign out_valid  = (r_state == S_DONE);
   assign out_sum    = r_out_sum;
   assign out_id     = r_out_id;
   assign busy       = !w_idle;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_op_id      <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_out_sum    <= '0;
         r_out_id     <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (|w_gnt) begin
               r_op_a       <= w_gnt_id ? req1_a : req0_a;
               r_op_b       <= w_gnt_id ? req1_b : req0_b;
               r_op_id      <= w_gnt_id;
               r_last_grant <= w_gnt_id;
               r_state      <= S_ADD;
            end
            S_ADD: begin
               r_out_sum <= w_y;
               r_out_id  <= r_op_id;
               r_state   <= S_DONE;
            end
            S_DONE: if (out_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed self-checking bench for the shared-adder arbiter
module tb_adder_share_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       out_valid, out_ready = 1'b1;
   logic [7:0] out_sum;
   logic       out_id, busy;
   int         n_checks = 0;
   int         n_fail = 0;

   adder_share_arbiter #(.N(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_id(out_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      req0_valid = 0; req1_valid = 0; out_ready = 1;
      do_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_checks++; if (out_sum !== 8'd0) begin n_fail++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
      n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL reset_out_id got %0b want 0", out_id); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready}); end
   endtask

   task automatic test_single;
      req0_a = 8'd123; req0_b = 8'd123; req0_valid = 1; #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b want 01", {req1_ready, req0_ready}); end
      tick();
      req0_valid = 0; #1;
      n_checks++; if ({busy, out_valid, req0_ready} !== 3'b100) begin n_fail++; $display("FAIL single_add_phase got busy/valid/ready %b want 100", {busy, out_valid, req0_ready}); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got out_valid %0b want 1", out_valid); end
      n_checks++; if (out_sum !== 8'd246) begin n_fail++; $display("FAIL single_sum got %0d want 246", out_sum); end
      n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL single_id got %0b want 0", out_id); end
      tick();
      n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_release got valid/busy %b want 00", {out_valid, busy}); end
   endtask

   task automatic test_both_from_reset;
      logic [7:0] sums [2];
      logic       ids [2];
      int         got = 0;
      bit         both_seen = 0;
      bit         r0, r1;
      req0_a = 8'd5; req0_b = 8'd6; req1_a = 8'd10; req1_b = 8'd20;
      req0_valid = 1; req1_valid = 1; out_ready = 1;
      do_reset();
      for (int c = 0; c < 30 && got < 2; c++) begin
         #1;
         r0 = req0_ready; r1 = req1_ready;
         if (r0 && r1) both_seen = 1;
         if (out_valid) begin sums[got] = out_sum; ids[got] = out_id; got++; end
         tick();
         if (r0) req0_valid = 0;
         if (r1) req1_valid = 0;
      end
      n_checks++; if (both_seen) begin n_fail++; $display("FAIL both_ready_exclusive got both high want never"); end
      n_checks++; if (got !== 2) begin n_fail++; $display("FAIL both_count got %0d results want 2", got); end
      if (got == 2) begin
         n_checks++; if ({sums[0], ids[0]} !== {8'd11, 1'b0}) begin n_fail++; $display("FAIL both_first got %0d id%0b want 11 id0", sums[0], ids[0]); end
         n_checks++; if ({sums[1], ids[1]} !== {8'd30, 1'b1}) begin n_fail++; $display("FAIL both_second got %0d id%0b want 30 id1", sums[1], ids[1]); end
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_wrap;
      int c = 0;
      req1_a = 8'd200; req1_b = 8'd100; req1_valid = 1; out_ready = 1; #1;
      n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready got %0b want 1", req1_ready); end
      tick();
      req1_valid = 0;
      while (!out_valid && c < 10) begin tick(); c++; end
      n_checks++; if ({out_valid, out_sum, out_id} !== {1'b1, 8'd44, 1'b1}) begin n_fail++; $display("FAIL wrap_result got v%0b %0d id%0b want v1 44 id1", out_valid, out_sum, out_id); end
      tick();
   endtask

   task automatic test_backpressure;
      int c = 0;
      out_ready = 0;
      req0_a = 8'd7; req0_b = 8'd9; req0_valid = 1; #1;
      tick();
      req0_valid = 0;
      while (!out_valid && c < 10) begin tick(); c++; end
      req0_valid = 1; req1_valid = 1;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++; if ({out_valid, out_sum, out_id, busy, req0_ready, req1_ready} !== {1'b1, 8'd16, 1'b0, 1'b1, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL bp_hold_%0d got v%0b %0d id%0b busy%0b rdy%b%b want v1 16 id0 busy1 rdy00", k, out_valid, out_sum, out_id, busy, req1_ready, req0_ready); end
         tick();
      end
      req0_valid = 0; req1_valid = 0; out_ready = 1;
      tick();
      n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_release got valid/busy %b want 00", {out_valid, busy}); end
   endtask

   task automatic test_alternate;
      logic exp_g [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_s [2] = '{8'd3, 8'd4};
      logic grants [6];
      logic [7:0] sums [6];
      logic ids [6];
      int ng = 0, no = 0;
      req0_a = 8'd1; req0_b = 8'd2; req1_a = 8'd250; req1_b = 8'd10;
      req0_valid = 0; req1_valid = 0; out_ready = 1;
      do_reset();
      req0_valid = 1; req1_valid = 1;
      for (int c = 0; c < 60 && no < 6; c++) begin
         #1;
         if ((req0_ready || req1_ready) && ng < 6) begin grants[ng] = req1_ready; ng++; end
         if (out_valid && no < 6) begin sums[no] = out_sum; ids[no] = out_id; no++; end
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      n_checks++; if (no !== 6) begin n_fail++; $display("FAIL alt_count got %0d results want 6", no); end
      for (int i = 0; i < ng; i++) begin
         n_checks++; if (grants[i] !== exp_g[i]) begin n_fail++; $display("FAIL alt_grant_%0d got %0b want %0b", i, grants[i], exp_g[i]); end
      end
      for (int i = 0; i < no; i++) begin
         n_checks++; if ({ids[i], sums[i]} !== {exp_g[i], exp_s[i % 2]}) begin n_fail++; $display("FAIL alt_out_%0d got id%0b %0d want id%0b %0d", i, ids[i], sums[i], exp_g[i], exp_s[i % 2]); end
      end
      tick();
      tick();
   endtask

   task automatic test_rst_in_done;
      int c = 0;
      out_ready = 0;
      req0_a = 8'd1; req0_b = 8'd2; req0_valid = 1; #1;
      tick();
      req0_valid = 0;
      while (!out_valid && c < 10) begin tick(); c++; end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_done_reached got %0b want 1", out_valid); end
      rst = 1;
      tick();
      rst = 0; #1;
      n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_done_clear got valid/busy %b want 00", {out_valid, busy}); end
      req0_valid = 1; req1_valid = 1; #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_done_pointer got %b want 01", {req1_ready, req0_ready}); end
      req0_valid = 0; req1_valid = 0; out_ready = 1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_both_from_reset();
      test_wrap();
      test_backpressure();
      test_alternate();
      test_rst_in_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
